// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle between the IF/ID/EXE pipeline and pipe_hazard_ctrl.
//   master : pipeline side, drives ID/EXE status and halt_req, receives controls
//   slave  : controller side, samples status, drives pc_en/stop/flush/bubble,
//            halted and the two event counters
interface pipe_hazard_ctrl_if #(
    parameter int REG_BITS = 4,
    parameter int CNT_W    = 16
);
    logic [REG_BITS-1:0] id_rs1, id_rs2, id_rs3;
    logic                id_use1, id_use2, id_use3;
    logic [REG_BITS-1:0] exe_rd;
    logic                exe_rd_mem;
    logic                exe_wb_en;
    logic                exe_branch_taken;
    logic                halt_req;
    logic                pc_en;
    logic                ifid_stop;
    logic                ifid_flush;
    logic                idexe_bubble;
    logic                halted;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs3, id_use1, id_use2, id_use3,
        output exe_rd, exe_rd_mem, exe_wb_en, exe_branch_taken, halt_req,
        input  pc_en, ifid_stop, ifid_flush, idexe_bubble, halted,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs3, id_use1, id_use2, id_use3,
        input  exe_rd, exe_rd_mem, exe_wb_en, exe_branch_taken, halt_req,
        output pc_en, ifid_stop, ifid_flush, idexe_bubble, halted,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard/sequencing controller: load-use stalls, taken-branch
// flushes, external halt, and saturating stall/flush event counters.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   hz  : pipe_hazard_ctrl_if.slave (ID/EXE status in, pipeline controls out)
// All controls are Mealy outputs of state plus current inputs.
module pipe_hazard_ctrl #(
    parameter int REG_BITS = 4,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_STALL = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    // The luh cycle is the first stall cycle, so STALL covers the rest.
    localparam logic [2:0] LCNT_INIT = 3'(LOAD_LAT - 1);

    logic [1:0]          state_q, state_d;
    logic [2:0]          lcnt_q, lcnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;

    logic [REG_BITS-1:0] rd_w;
    logic                luh;
    logic                pc_en_c, stop_c, flush_c, bubble_c, halted_c;

    assign rd_w = hz.exe_rd;
    assign luh  = hz.exe_rd_mem & hz.exe_wb_en &
                  ((hz.id_use1 & (hz.id_rs1 == rd_w)) |
                   (hz.id_use2 & (hz.id_rs2 == rd_w)) |
                   (hz.id_use3 & (hz.id_rs3 == rd_w)));

    always_comb begin
        state_d  = state_q;
        lcnt_d   = lcnt_q;
        pc_en_c  = 1'b1;
        stop_c   = 1'b0;
        flush_c  = 1'b0;
        bubble_c = 1'b0;
        halted_c = 1'b0;
        case (state_q)
            S_RUN: begin
                if (hz.exe_branch_taken) begin
                    // ID instruction is squashed, so its luh/halt are moot.
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                end else if (luh) begin
                    pc_en_c  = 1'b0;
                    stop_c   = 1'b1;
                    bubble_c = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = S_STALL;
                        lcnt_d  = LCNT_INIT;
                    end
                end else if (hz.halt_req) begin
                    state_d = S_HALT;
                end
            end
            S_STALL: begin
                pc_en_c  = 1'b0;
                stop_c   = 1'b1;
                bubble_c = 1'b1;
                lcnt_d   = lcnt_q - 3'd1;
                if (lcnt_q == 3'd1) state_d = S_RUN;
            end
            S_HALT: begin
                pc_en_c  = 1'b0;
                stop_c   = 1'b1;
                bubble_c = 1'b1;
                halted_c = 1'b1;
                if (!hz.halt_req) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_RUN;
            lcnt_q      <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            lcnt_q  <= lcnt_d;
            if (!pc_en_c && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_c && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    // Reset forces every control low asynchronously.
    assign hz.pc_en        = rst & pc_en_c;
    assign hz.ifid_stop    = rst & stop_c;
    assign hz.ifid_flush   = rst & flush_c;
    assign hz.idexe_bubble = rst & bubble_c;
    assign hz.halted       = rst & halted_c;
    assign hz.stall_cnt    = stall_cnt_q;
    assign hz.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Two controllers share one stimulus: A (LOAD_LAT=1, CNT_W=16) and
// B (LOAD_LAT=3, CNT_W=4). Expected controls/counters are queued per cycle.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] rs1, rs2, rs3, rd;
    logic u1, u2, u3, mem, wb, br, halt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_BITS(4), .CNT_W(16)) ifa ();
    pipe_hazard_ctrl_if #(.REG_BITS(4), .CNT_W(4))  ifb ();

    assign ifa.id_rs1 = rs1;  assign ifb.id_rs1 = rs1;
    assign ifa.id_rs2 = rs2;  assign ifb.id_rs2 = rs2;
    assign ifa.id_rs3 = rs3;  assign ifb.id_rs3 = rs3;
    assign ifa.id_use1 = u1;  assign ifb.id_use1 = u1;
    assign ifa.id_use2 = u2;  assign ifb.id_use2 = u2;
    assign ifa.id_use3 = u3;  assign ifb.id_use3 = u3;
    assign ifa.exe_rd = rd;   assign ifb.exe_rd = rd;
    assign ifa.exe_rd_mem = mem;       assign ifb.exe_rd_mem = mem;
    assign ifa.exe_wb_en = wb;         assign ifb.exe_wb_en = wb;
    assign ifa.exe_branch_taken = br;  assign ifb.exe_branch_taken = br;
    assign ifa.halt_req = halt;        assign ifb.halt_req = halt;

    pipe_hazard_ctrl #(.REG_BITS(4), .LOAD_LAT(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst_n), .hz(ifa)
    );
    pipe_hazard_ctrl #(.REG_BITS(4), .LOAD_LAT(3), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst_n), .hz(ifb)
    );

    // {pc_en, ifid_stop, ifid_flush, idexe_bubble, halted}
    localparam logic [4:0] C_RST = 5'b00000;
    localparam logic [4:0] C_RUN = 5'b10000;
    localparam logic [4:0] C_STL = 5'b01010;
    localparam logic [4:0] C_FL  = 5'b10110;
    localparam logic [4:0] C_HLT = 5'b01011;

    typedef struct {
        logic [4:0] ctl;
        int         sc;
        int         fc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; rs3 = 0; rd = 0;
        u1 = 0; u2 = 0; u3 = 0; mem = 0; wb = 0; br = 0; halt = 0;
    endtask

    // Inputs were driven at the falling edge; push expectations, sample
    // 1 ns later, then advance to the next falling edge.
    task automatic step(input string tag,
                        input logic [4:0] ca, input int sca, input int fca,
                        input logic [4:0] cb, input int scb, input int fcb);
        exp_t e;
        e.ctl = ca; e.sc = sca; e.fc = fca; qa.push_back(e);
        e.ctl = cb; e.sc = scb; e.fc = fcb; qb.push_back(e);
        #1;
        e = qa.pop_front();
        chk({tag, ".A.ctl"}, 32'({ifa.pc_en, ifa.ifid_stop, ifa.ifid_flush,
                                  ifa.idexe_bubble, ifa.halted}), 32'(e.ctl));
        chk({tag, ".A.scnt"}, 32'(ifa.stall_cnt), e.sc);
        chk({tag, ".A.fcnt"}, 32'(ifa.flush_cnt), e.fc);
        e = qb.pop_front();
        chk({tag, ".B.ctl"}, 32'({ifb.pc_en, ifb.ifid_stop, ifb.ifid_flush,
                                  ifb.idexe_bubble, ifb.halted}), 32'(e.ctl));
        chk({tag, ".B.scnt"}, 32'(ifb.stall_cnt), e.sc);
        chk({tag, ".B.fcnt"}, 32'(ifb.flush_cnt), e.fc);
        @(negedge clk);
    endtask

    task automatic luh_rs2();
        idle(); mem = 1; wb = 1; rd = 5; u2 = 1; rs2 = 5;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        step("rst", C_RST, 0, 0, C_RST, 0, 0);
        rst_n = 1'b1;
        step("rel", C_RUN, 0, 0, C_RUN, 0, 0);

        // load-use on rs2
        luh_rs2();            step("luh2",  C_STL, 0, 0, C_STL, 0, 0);
        idle();               step("luh2a", C_RUN, 1, 0, C_STL, 1, 0);
        idle();               step("luh2b", C_RUN, 1, 0, C_STL, 2, 0);
        idle();               step("luh2c", C_RUN, 1, 0, C_RUN, 3, 0);
        luh_rs2(); u2 = 0;    step("nouse", C_RUN, 1, 0, C_RUN, 3, 0);

        // load-use on rs1
        idle(); mem = 1; wb = 1; rd = 5; u1 = 1; rs1 = 5;
                              step("luh1",  C_STL, 1, 0, C_STL, 3, 0);
        idle();               step("luh1a", C_RUN, 2, 0, C_STL, 4, 0);
        idle();               step("luh1b", C_RUN, 2, 0, C_STL, 5, 0);

        // rs3 path and its qualifiers
        idle(); mem = 1; wb = 0; rd = 5; u3 = 1; rs3 = 5;
                              step("nowb",  C_RUN, 2, 0, C_RUN, 6, 0);
        mem = 0; wb = 1;      step("nomem", C_RUN, 2, 0, C_RUN, 6, 0);
        mem = 1; rd = 6;      step("norda", C_RUN, 2, 0, C_RUN, 6, 0);
        rd = 5;               step("luh3",  C_STL, 2, 0, C_STL, 6, 0);
        idle();               step("luh3a", C_RUN, 3, 0, C_STL, 7, 0);

        // reset in B's second stall cycle, checked before any clock edge
        rst_n = 1'b0;         step("arst",  C_RST, 0, 0, C_RST, 0, 0);
        rst_n = 1'b1;         step("arel",  C_RUN, 0, 0, C_RUN, 0, 0);

        // branch beats concurrent luh and halt; halt then taken next cycle
        luh_rs2(); br = 1; halt = 1;
                              step("brpri", C_FL,  0, 0, C_FL,  0, 0);
        idle(); halt = 1;     step("brh1",  C_RUN, 0, 1, C_RUN, 0, 1);
        halt = 1;             step("brh2",  C_HLT, 0, 1, C_HLT, 0, 1);
        halt = 0;             step("brh3",  C_HLT, 1, 1, C_HLT, 1, 1);
        idle();               step("brh4",  C_RUN, 2, 1, C_RUN, 2, 1);

        // halt_req for 4 cycles
        halt = 1;             step("h4a",   C_RUN, 2, 1, C_RUN, 2, 1);
        halt = 1;             step("h4b",   C_HLT, 2, 1, C_HLT, 2, 1);
        halt = 1;             step("h4c",   C_HLT, 3, 1, C_HLT, 3, 1);
        halt = 1;             step("h4d",   C_HLT, 4, 1, C_HLT, 4, 1);
        halt = 0;             step("h4e",   C_HLT, 5, 1, C_HLT, 5, 1);
        idle();               step("h4f",   C_RUN, 6, 1, C_RUN, 6, 1);

        // halt arriving while B is stalled is deferred until RUN
        luh_rs2();            step("dh0",   C_STL, 6, 1, C_STL, 6, 1);
        idle(); halt = 1;     step("dh1",   C_RUN, 7, 1, C_STL, 7, 1);
        halt = 1;             step("dh2",   C_HLT, 7, 1, C_STL, 8, 1);
        halt = 1;             step("dh3",   C_HLT, 8, 1, C_RUN, 9, 1);
        halt = 0;             step("dh4",   C_HLT, 9, 1, C_HLT, 9, 1);
        idle();               step("dh5",   C_RUN, 10, 1, C_RUN, 10, 1);

        // 20 consecutive flushes: B's 4-bit flush counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            idle(); br = 1;
            step("brsat", C_FL, 10, 1 + i, C_FL, 10, (1 + i > 15) ? 15 : 1 + i);
        end
        idle();               step("brsatf", C_RUN, 10, 21, C_RUN, 10, 15);

        // long halt: B's stall counter saturates at 15
        for (int i = 0; i < 12; i++) begin
            idle(); halt = 1;
            if (i == 0)
                step("hsat", C_RUN, 10, 21, C_RUN, 10, 15);
            else
                step("hsat", C_HLT, 9 + i, 21, C_HLT, (9 + i > 15) ? 15 : 9 + i, 15);
        end
        halt = 0;             step("hsate", C_HLT, 21, 21, C_HLT, 15, 15);
        idle();               step("hsatf", C_RUN, 22, 21, C_RUN, 15, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
